pc_gen: RTL and testbench

- Parametrised next-generation fetch PC generator at the head of the front end; drives the fetch-block address into the ICache/BPU stage.
- Extends the single-redirect PC register with:
  - N prioritised redirect channels (e.g. exception/ertn, backend mispredict, BPU prediction).
  - Configurable fetch-block width and reset vector.
  - A valid/ready handshake toward fetch.
  - A boot/run/halt state machine.
  - A misaligned-target (ADEF) flag.

---
 rtl/bpu_pkg.sv | 23 ++
 rtl/pc_gen_if.sv | 27 ++
 rtl/redir_arbiter.sv | 31 +++
 rtl/pc_gen.sv | 93 +++++++++
 tb/tb_pc_gen.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/bpu_pkg.sv
// Shared front-end definitions: PC width, reset vector, fetch block size,
// generator states and redirect channel indices.
package bpu_pkg;

  localparam int               ADDR_W      = 32;
  localparam int               N_REDIR     = 3;
  localparam int               FETCH_BYTES = 8;
  localparam logic [ADDR_W-1:0] RESET_PC   = 32'h1c00_0000;

  typedef logic [ADDR_W-1:0] pc_t;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pcgen_state_e;

  // Redirect channels, highest priority first.
  localparam int REDIR_EXC     = 0;
  localparam int REDIR_BACKEND = 1;
  localparam int REDIR_BPU     = 2;

endpackage

// File: rtl/pc_gen_if.sv
// Redirect inputs, halt and the fetch-request handshake of the PC generator.
interface pc_gen_if #(
  parameter int ADDR_W  = 32,
  parameter int N_REDIR = 3
);

  logic [N_REDIR-1:0]        redir_valid_i;
  logic [N_REDIR*ADDR_W-1:0] redir_target_i;
  logic                      halt_i;
  logic                      fetch_ready_i;
  logic                      pc_valid_o;
  logic [ADDR_W-1:0]         pc_o;
  logic                      adef_o;
  logic [N_REDIR-1:0]        redir_sel_o;

  // The PC generator is the requester toward fetch.
  modport master (
    input  redir_valid_i, redir_target_i, halt_i, fetch_ready_i,
    output pc_valid_o, pc_o, adef_o, redir_sel_o
  );

  modport slave (
    output redir_valid_i, redir_target_i, halt_i, fetch_ready_i,
    input  pc_valid_o, pc_o, adef_o, redir_sel_o
  );

endinterface

// File: rtl/redir_arbiter.sv
// Fixed-priority redirect picker: lowest asserted index wins; returns the
// one-hot grant and the matching target. Purely combinational.
module redir_arbiter #(
  parameter int N = 3,
  parameter int W = 32
) (
  input  logic [N-1:0]   valid,
  input  logic [N*W-1:0] targets,
  output logic           any,
  output logic [N-1:0]   sel,
  output logic [W-1:0]   target
);

  assign any = |valid;

  // NOTE: every output of this block is assigned a default before the loop,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    sel    = '0;
    target = '0;
    // Scan from the top so the lowest asserted index is the last write.
    for (int k = N - 1; k >= 0; k--) begin
      if (valid[k]) begin
        sel    = '0;
        sel[k] = 1'b1;
        target = targets[k*W +: W];
      end
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: prioritised redirects, block-aligned sequential
// increment, BOOT/RUN/HALT control and a misaligned-target (ADEF) flag.
module pc_gen #(
  parameter int                ADDR_W      = bpu_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC    = bpu_pkg::RESET_PC,
  parameter int                FETCH_BYTES = bpu_pkg::FETCH_BYTES,
  parameter int                N_REDIR     = bpu_pkg::N_REDIR
) (
  input  logic      clk,
  input  logic      rst_n,
  pc_gen_if.master  bus
);

  import bpu_pkg::*;

  localparam int OFF = $clog2(FETCH_BYTES);
  localparam logic [ADDR_W-OFF-1:0] BLK_ONE = {{(ADDR_W-OFF-1){1'b0}}, 1'b1};

  pcgen_state_e        state;
  logic [ADDR_W-1:0]   pc_q;
  logic                valid_q;
  logic                adef_q;
  logic [N_REDIR-1:0]  sel_q;

  logic                any_redir;
  logic [N_REDIR-1:0]  win_sel;
  logic [ADDR_W-1:0]   win_target;
  logic [ADDR_W-1:0]   pc_inc;

  redir_arbiter #(
    .N (N_REDIR),
    .W (ADDR_W)
  ) u_arb (
    .valid   (bus.redir_valid_i),
    .targets (bus.redir_target_i),
    .any     (any_redir),
    .sel     (win_sel),
    .target  (win_target)
  );

  // Next block always aligns down, so a misaligned target costs one partial
  // block; the all-ones block wraps silently to zero.
  assign pc_inc = {pc_q[ADDR_W-1:OFF] + BLK_ONE, {OFF{1'b0}}};

  // NOTE: state and outputs use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= BOOT;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      adef_q  <= 1'b0;
      sel_q   <= '0;
    end else begin
      sel_q <= '0;
      if (any_redir) begin
        // A redirect squashes the in-flight PC whatever the state or stall.
        state   <= RUN;
        pc_q    <= win_target;
        valid_q <= 1'b1;
        adef_q  <= (win_target[1:0] != 2'b00);
        sel_q   <= win_sel;
      end else begin
        case (state)
          BOOT: begin
            state   <= RUN;
            valid_q <= 1'b1;
          end
          RUN: begin
            if (bus.halt_i) begin
              state   <= HALT;
              valid_q <= 1'b0;
            end else if (bus.fetch_ready_i) begin
              pc_q   <= pc_inc;
              adef_q <= 1'b0;
            end
          end
          HALT: ;
          default: begin
            state   <= BOOT;
            valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.pc_valid_o  = valid_q;
  assign bus.pc_o        = pc_q;
  assign bus.adef_o      = adef_q;
  assign bus.redir_sel_o = sel_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed scoreboard bench for pc_gen: expected outputs are queued as each
// cycle's stimulus is driven and popped when the DUT has registered it.
module tb_pc_gen;

  import bpu_pkg::*;

  localparam int AW = 32;
  localparam int NR = 3;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  pc_gen_if #(.ADDR_W(AW), .N_REDIR(NR)) bus ();

  pc_gen #(
    .ADDR_W      (AW),
    .RESET_PC    (RESET_PC),
    .FETCH_BYTES (FETCH_BYTES),
    .N_REDIR     (NR)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string       tag;
    logic        valid;
    logic [31:0] pc;
    logic        adef;
    logic [2:0]  sel;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [31:0] pc,
                            input logic a, input logic [2:0] s);
    exp_t e;
    e.tag = tag; e.valid = v; e.pc = pc; e.adef = a; e.sel = s;
    sb.push_back(e);
  endtask

  task automatic compare_head();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({e.tag, ".valid"}, {31'd0, bus.pc_valid_o}, {31'd0, e.valid});
      check({e.tag, ".pc"},    bus.pc_o, e.pc);
      check({e.tag, ".adef"},  {31'd0, bus.adef_o}, {31'd0, e.adef});
      check({e.tag, ".sel"},   {29'd0, bus.redir_sel_o}, {29'd0, e.sel});
    end
  endtask

  task automatic drive(input logic [2:0] v, input logic [31:0] t0, input logic [31:0] t1,
                       input logic [31:0] t2, input logic halt, input logic rdy);
    bus.redir_valid_i  = v;
    bus.redir_target_i = {t2, t1, t0};
    bus.halt_i         = halt;
    bus.fetch_ready_i  = rdy;
  endtask

  task automatic idle(input logic rdy, input logic halt);
    drive(3'b000, 32'h0, 32'h0, 32'h0, halt, rdy);
  endtask

  // Inputs are already driven; the expectation covers the next clock edge.
  task automatic step(input string tag, input logic v, input logic [31:0] pc,
                      input logic a, input logic [2:0] s);
    expect_out(tag, v, pc, a, s);
    @(posedge clk);
    @(negedge clk);
    compare_head();
  endtask

  // Reset asserted mid-cycle must take effect without a clock edge.
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    expect_out({tag, "_now"}, 1'b0, RESET_PC, 1'b0, 3'b000);
    compare_head();
    check({tag, "_state"}, 32'(dut.state), 32'(BOOT));
    @(negedge clk);
    rst_n = 1'b1;
    expect_out({tag, "_boot"}, 1'b0, RESET_PC, 1'b0, 3'b000);
    compare_head();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] ch_exc, ch_be, ch_bpu;
    ch_exc = 3'(1 << REDIR_EXC);
    ch_be  = 3'(1 << REDIR_BACKEND);
    ch_bpu = 3'(1 << REDIR_BPU);

    rst_n = 1'b0;
    idle(1'b1, 1'b0);
    repeat (2) @(negedge clk);
    expect_out("reset", 1'b0, 32'h1c00_0000, 1'b0, 3'b000);
    compare_head();
    rst_n = 1'b1;
    expect_out("boot_cycle0", 1'b0, 32'h1c00_0000, 1'b0, 3'b000);
    compare_head();
    check("boot_state", 32'(dut.state), 32'(BOOT));

    // Boot then sequential fetch.
    step("run0", 1'b1, 32'h1c00_0000, 1'b0, 3'b000);
    step("seq1", 1'b1, 32'h1c00_0008, 1'b0, 3'b000);
    step("seq2", 1'b1, 32'h1c00_0010, 1'b0, 3'b000);

    // Stall holds, then a redirect overrides the stall.
    idle(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("stall", 1'b1, 32'h1c00_0010, 1'b0, 3'b000);
    drive(ch_be, 32'h0, 32'h1c00_0100, 32'h0, 1'b0, 1'b0);
    step("redir_stall", 1'b1, 32'h1c00_0100, 1'b0, 3'b010);
    idle(1'b0, 1'b0);
    step("sel_clear", 1'b1, 32'h1c00_0100, 1'b0, 3'b000);

    // Priority across all three channels.
    drive(3'b111, 32'h1c00_8000, 32'h1c00_0200, 32'h1c00_0300, 1'b0, 1'b1);
    step("prio", 1'b1, 32'h1c00_8000, 1'b0, 3'b001);
    idle(1'b1, 1'b0);
    step("prio_next", 1'b1, 32'h1c00_8008, 1'b0, 3'b000);

    // Misaligned target: partial block, flag stable across a stall.
    drive(ch_be, 32'h0, 32'h1c00_0106, 32'h0, 1'b0, 1'b1);
    step("mis_redir", 1'b1, 32'h1c00_0106, 1'b1, 3'b010);
    idle(1'b0, 1'b0);
    step("mis_stall", 1'b1, 32'h1c00_0106, 1'b1, 3'b000);
    idle(1'b1, 1'b0);
    step("mis_next", 1'b1, 32'h1c00_0108, 1'b0, 3'b000);
    drive(ch_bpu, 32'h0, 32'h0, 32'h1c00_0104, 1'b0, 1'b1);
    step("half_redir", 1'b1, 32'h1c00_0104, 1'b0, 3'b100);
    idle(1'b1, 1'b0);
    step("half_next", 1'b1, 32'h1c00_0108, 1'b0, 3'b000);

    // Halt: frozen, and dropping halt_i alone does not resume.
    idle(1'b1, 1'b1);
    step("halt0", 1'b0, 32'h1c00_0108, 1'b0, 3'b000);
    step("halt1", 1'b0, 32'h1c00_0108, 1'b0, 3'b000);
    idle(1'b1, 1'b0);
    step("halt_hold", 1'b0, 32'h1c00_0108, 1'b0, 3'b000);

    // Redirect leaves HALT; increment wraps at the top of the space.
    drive(ch_bpu, 32'h0, 32'h0, 32'hffff_fff8, 1'b1, 1'b1);
    step("wake", 1'b1, 32'hffff_fff8, 1'b0, 3'b100);
    idle(1'b1, 1'b0);
    step("wrap", 1'b1, 32'h0000_0000, 1'b0, 3'b000);

    // Redirect beats halt in RUN.
    drive(ch_exc, 32'h1c00_0040, 32'h0, 32'h0, 1'b1, 1'b1);
    step("redir_over_halt", 1'b1, 32'h1c00_0040, 1'b0, 3'b001);
    idle(1'b0, 1'b0);
    step("pre_rst_stall", 1'b1, 32'h1c00_0040, 1'b0, 3'b000);

    // Asynchronous reset during a stall.
    async_reset("rst_stall");
    idle(1'b1, 1'b0);
    step("rerun", 1'b1, 32'h1c00_0000, 1'b0, 3'b000);
    idle(1'b1, 1'b1);
    step("rehalt", 1'b0, 32'h1c00_0000, 1'b0, 3'b000);

    // Asynchronous reset in HALT, then a redirect during BOOT.
    async_reset("rst_halt");
    drive(ch_be, 32'h0, 32'h1c00_0020, 32'h0, 1'b0, 1'b1);
    step("boot_redir", 1'b1, 32'h1c00_0020, 1'b0, 3'b010);
    idle(1'b1, 1'b0);
    step("boot_redir_next", 1'b1, 32'h1c00_0028, 1'b0, 3'b000);

    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
